spi_shifter_n: RTL and testbench
================================

SPI_SHIFTER_N -- requirements
Module: spi_shifter_n

Interface
REQ-001 Parameter DATA_WIDTH, default 8, shift register and word width in bits; legal range 2..32.
REQ-002 Parameter MSB_FIRST, default 1: 1 = MSB shifted out first, 0 = LSB shifted out first.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 load  input  1  capture load_data into the shift register and start a frame.
REQ-006 load_data  input  DATA_WIDTH  parallel word to transmit.
REQ-007 shift_en  input  1  perform one shift this cycle when a frame is active.
REQ-008 serial_in  input  1  receive bit, sampled on shift cycles.
REQ-009 serial_out  output  1  transmit bit, the current outgoing end of the shift register.
REQ-010 data_out  output  DATA_WIDTH  last fully received word, held until the next frame completes.
REQ-011 busy  output  1  frame active.
REQ-012 done  output  1  one-cycle pulse: frame complete, data_out updated.
REQ-013 bit_cnt  output  $clog2(DATA_WIDTH+1)  shifts completed in the current frame.

Function
REQ-014 States: IDLE (busy=0), SHIFT (busy=1); the state is the busy flag.
REQ-015 load=1 in any state: sr <= load_data, bit_cnt <= 0, busy <= 1 on the next edge.
REQ-016 load has priority over shift_en in the same cycle; that shift_en is discarded.
REQ-017 load during SHIFT aborts the current frame: no done pulse, data_out unchanged, new frame starts.
REQ-018 SHIFT with shift_en=1 and load=0, MSB_FIRST=1: sr <= {sr[W-2:0], serial_in}; bit_cnt increments by 1.
REQ-019 SHIFT with shift_en=1 and load=0, MSB_FIRST=0: sr <= {serial_in, sr[W-1:1]}; bit_cnt increments by 1.
REQ-020 serial_out is combinational from sr: sr[W-1] when MSB_FIRST=1, sr[0] when MSB_FIRST=0.
REQ-021 SHIFT with shift_en=0 holds sr, bit_cnt and busy unchanged.
REQ-022 The shift that brings bit_cnt to DATA_WIDTH also loads the post-shift sr into data_out, clears busy and sets done for exactly the next cycle.
REQ-023 bit_cnt remains at DATA_WIDTH in IDLE after completion until the next load or reset; it never exceeds DATA_WIDTH.
REQ-024 shift_en in IDLE is ignored: sr, bit_cnt and data_out are unchanged.
REQ-025 done=1 only in the cycle directly following the completing shift, including when load is asserted in that cycle.
REQ-026 Completion latency: DATA_WIDTH shift cycles after load; done is high on the cycle after the DATA_WIDTH-th shift edge.

Reset
REQ-027 rst=1 at a rising edge sets sr=0, data_out=0, bit_cnt=0, busy=0 and done=0; serial_out then reads 0.
REQ-028 rst has priority over load and shift_en, and aborts an active frame with no done pulse.
REQ-029 Outputs are defined from the first clock edge with rst=1; there is no asynchronous path.

Verification
REQ-030 W=8, MSB_FIRST=1: load 0xA5, then 8 shift_en cycles with serial_in driving the bits of 0x3C MSB first -> serial_out sequence 1,0,1,0,0,1,0,1; data_out=0x3C; done pulses once; busy=0.
REQ-031 W=8, MSB_FIRST=0: load 0xA5, shift in 0x3C LSB first -> serial_out sequence 1,0,1,0,0,1,0,1 (LSB first); data_out=0x3C.
REQ-032 shift_en gaps: load 0xFF, 8 shifts interleaved with 3 idle cycles -> completion after exactly 8 shifts; bit_cnt holds during the gaps.
REQ-033 Abort: load 0x11, 4 shifts, then load 0x22 together with shift_en -> bit_cnt=0, sr=0x22, no done pulse, previous data_out retained.
REQ-034 rst asserted after 5 of 8 shifts -> all outputs 0 on the next edge; later shift_en with no load has no effect.
REQ-035 W=16, MSB_FIRST=1: load 0xBEEF in loopback (serial_out tied to serial_in), 16 shifts -> data_out=0xBEEF; bit_cnt=16.

Source files
------------

// File: rtl/spi_shifter_n.sv
// Parameterised SPI-style shift register: parallel load, serial shift
// in/out, framed by a bit counter with a one-cycle completion pulse.
module spi_shifter_n #(
    parameter int DATA_WIDTH = 8,
    parameter bit MSB_FIRST  = 1'b1,
    localparam int CNT_W     = $clog2(DATA_WIDTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  shift_en,
    input  logic                  serial_in,
    output logic                  serial_out,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_W-1:0]      bit_cnt
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t                state;
    logic [DATA_WIDTH-1:0] sr;
    logic [DATA_WIDTH-1:0] sr_shift;
    logic                  shift_go;

    generate
        if (MSB_FIRST) begin : g_msb
            assign sr_shift   = {sr[DATA_WIDTH-2:0], serial_in};
            assign serial_out = sr[DATA_WIDTH-1];
        end else begin : g_lsb
            assign sr_shift   = {serial_in, sr[DATA_WIDTH-1:1]};
            assign serial_out = sr[0];
        end
    endgenerate

    assign shift_go = (state == SHIFT) && shift_en;
    assign busy     = (state == SHIFT);

    // load wins over shift_en and restarts any frame in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            sr       <= '0;
            data_out <= '0;
            bit_cnt  <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                state   <= SHIFT;
                sr      <= load_data;
                bit_cnt <= '0;
            end else if (shift_go) begin
                sr      <= sr_shift;
                bit_cnt <= bit_cnt + CNT_ONE;
                if (bit_cnt == LAST_BIT) begin
                    state    <= IDLE;
                    data_out <= sr_shift;
                    done     <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_shifter_n.sv
// Directed bench for spi_shifter_n: MSB/LSB-first 8-bit instances
// plus a 16-bit loopback instance, all sharing reset and control.
module tb_spi_shifter_n;

    logic        clk;
    logic        rst;
    logic        load;
    logic        shift_en;
    logic [7:0]  ld8;
    logic [15:0] ld16;
    logic        si_m;
    logic        si_l;
    logic        si16;

    logic        so_m, so_l, so16;
    logic [7:0]  do_m, do_l;
    logic [15:0] do16;
    logic        busy_m, busy_l, busy16;
    logic        done_m, done_l, done16;
    logic [3:0]  cnt_m, cnt_l;
    logic [4:0]  cnt16;

    int checks = 0;
    int failures = 0;

    logic [7:0]  a5   = 8'hA5;
    logic [7:0]  x3c  = 8'h3C;
    logic [7:0]  x22  = 8'h22;
    logic [7:0]  x5a  = 8'h5A;

    spi_shifter_n #(.DATA_WIDTH(8), .MSB_FIRST(1'b1)) u_m (
        .clk(clk), .rst(rst), .load(load), .load_data(ld8),
        .shift_en(shift_en), .serial_in(si_m), .serial_out(so_m),
        .data_out(do_m), .busy(busy_m), .done(done_m), .bit_cnt(cnt_m)
    );

    spi_shifter_n #(.DATA_WIDTH(8), .MSB_FIRST(1'b0)) u_l (
        .clk(clk), .rst(rst), .load(load), .load_data(ld8),
        .shift_en(shift_en), .serial_in(si_l), .serial_out(so_l),
        .data_out(do_l), .busy(busy_l), .done(done_l), .bit_cnt(cnt_l)
    );

    spi_shifter_n #(.DATA_WIDTH(16), .MSB_FIRST(1'b1)) u_w (
        .clk(clk), .rst(rst), .load(load), .load_data(ld16),
        .shift_en(shift_en), .serial_in(si16), .serial_out(so16),
        .data_out(do16), .busy(busy16), .done(done16), .bit_cnt(cnt16)
    );

    assign si16 = so16;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; shift_en = 1'b0;
        ld8 = '0; ld16 = '0; si_m = 1'b0; si_l = 1'b0;
        tick();
        rst = 1'b0;
        check("rst_do", 32'(do_m), 32'h0);
        check("rst_cnt", 32'(cnt_m), 32'h0);
        check("rst_busy", 32'(busy_m), 32'h0);
        check("rst_done", 32'(done_m), 32'h0);
        check("rst_so", 32'(so_m), 32'h0);

        // basic frame, both bit orders together
        load = 1'b1; ld8 = 8'hA5;
        tick();
        load = 1'b0;
        check("ld_busy", 32'(busy_m), 32'h1);
        check("ld_cnt", 32'(cnt_m), 32'h0);
        for (int i = 0; i < 8; i++) begin
            check("msb_so", 32'(so_m), 32'(a5[7-i]));
            check("lsb_so", 32'(so_l), 32'(a5[i]));
            check("mid_done", 32'(done_m), 32'h0);
            shift_en = 1'b1;
            si_m = x3c[7-i];
            si_l = x3c[i];
            tick();
        end
        check("msb_do", 32'(do_m), 32'h3C);
        check("lsb_do", 32'(do_l), 32'h3C);
        check("msb_done", 32'(done_m), 32'h1);
        check("lsb_done", 32'(done_l), 32'h1);
        check("end_busy", 32'(busy_m), 32'h0);
        check("end_cnt", 32'(cnt_m), 32'h8);
        // shift_en kept high while idle must do nothing
        si_m = 1'b1;
        tick();
        check("idle_done", 32'(done_m), 32'h0);
        check("idle_cnt", 32'(cnt_m), 32'h8);
        check("idle_do", 32'(do_m), 32'h3C);
        check("idle_so", 32'(so_m), 32'(x3c[7]));

        // shifts with idle gaps
        shift_en = 1'b0;
        load = 1'b1; ld8 = 8'hFF;
        tick();
        load = 1'b0;
        si_m = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            shift_en = 1'b1;
            tick();
            check("gap_cnt", 32'(cnt_m), 32'(i));
            if (i == 2 || i == 4 || i == 6) begin
                shift_en = 1'b0;
                tick();
                check("gap_hold", 32'(cnt_m), 32'(i));
                check("gap_busy", 32'(busy_m), 32'h1);
            end
            if (i == 7) check("gap_nodone", 32'(done_m), 32'h0);
        end
        check("gap_do", 32'(do_m), 32'hFF);
        // load in the done cycle: pulse still visible
        shift_en = 1'b0;
        load = 1'b1; ld8 = 8'h11;
        #1;
        check("gap_done", 32'(done_m), 32'h1);
        tick();
        load = 1'b0;
        check("ab_done0", 32'(done_m), 32'h0);

        // abort by reload mid-frame
        si_m = 1'b0;
        shift_en = 1'b1;
        repeat (4) tick();
        check("ab_cnt4", 32'(cnt_m), 32'h4);
        load = 1'b1; ld8 = 8'h22;
        tick();
        load = 1'b0;
        check("ab_cnt0", 32'(cnt_m), 32'h0);
        check("ab_busy", 32'(busy_m), 32'h1);
        check("ab_done", 32'(done_m), 32'h0);
        check("ab_do", 32'(do_m), 32'hFF);
        for (int i = 0; i < 8; i++) begin
            check("ab_so", 32'(so_m), 32'(x22[7-i]));
            si_m = x5a[7-i];
            tick();
        end
        check("ab_do2", 32'(do_m), 32'h5A);
        check("ab_done2", 32'(done_m), 32'h1);

        // reset mid-frame
        load = 1'b1; ld8 = 8'h96;
        shift_en = 1'b0;
        tick();
        load = 1'b0;
        shift_en = 1'b1;
        repeat (5) tick();
        check("r5_cnt", 32'(cnt_m), 32'h5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("r_do", 32'(do_m), 32'h0);
        check("r_cnt", 32'(cnt_m), 32'h0);
        check("r_busy", 32'(busy_m), 32'h0);
        check("r_done", 32'(done_m), 32'h0);
        check("r_so", 32'(so_m), 32'h0);
        si_m = 1'b1;
        repeat (3) tick();
        check("r_se_cnt", 32'(cnt_m), 32'h0);
        check("r_se_busy", 32'(busy_m), 32'h0);
        check("r_se_do", 32'(do_m), 32'h0);
        check("r_se_so", 32'(so_m), 32'h0);

        // 16-bit loopback
        shift_en = 1'b0;
        load = 1'b1; ld16 = 16'hBEEF;
        tick();
        load = 1'b0;
        shift_en = 1'b1;
        repeat (15) tick();
        check("w_cnt15", 32'(cnt16), 32'd15);
        check("w_nodone", 32'(done16), 32'h0);
        tick();
        shift_en = 1'b0;
        check("w_do", 32'(do16), 32'hBEEF);
        check("w_cnt", 32'(cnt16), 32'd16);
        check("w_done", 32'(done16), 32'h1);
        check("w_busy", 32'(busy16), 32'h0);
        tick();
        check("w_done_off", 32'(done16), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
